// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I field-bundle to instruction-word encoder with output FIFO
//
// Packs RV32I instruction fields (R/I/S/B/U/J formats) into 32-bit words. It
// queues the words in a DEPTH-entry FIFO and streams them out, each tagged with
// a word address, towards an instruction-memory write port.
//
// Optional feature: define IMM_RANGE_CHECK_EN to reject bundles whose immediate
// does not fit the selected format.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   flush           synchronous clear of FIFO and address counter
//   in_valid/ready  field-bundle handshake
//   fmt             0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   opcode, funct3, funct7, rd, rs1, rs2, imm   instruction fields
//   out_valid/ready encoded-word handshake
//   out_instr       head-of-FIFO word; holds the last popped word when empty
//   out_addr        byte address of out_instr
//   count           FIFO occupancy
//   enc_err         one-cycle pulse after an accepted bundle was rejected
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 fmt,
  input  logic [6:0]                 opcode,
  input  logic [2:0]                 funct3,
  input  logic [6:0]                 funct7,
  input  logic [4:0]                 rd,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic [31:0]                imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_addr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       enc_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   last_q, last_d;
  logic          enc_err_q, enc_err_d;

  logic [31:0]   enc_word;
  logic          bad_fmt;
  logic          range_err;
  logic          full, empty, accept, push, pop;

  always_comb begin
    enc_word = 32'h0;
    bad_fmt  = 1'b0;
    case (fmt)
      3'd0: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      3'd1: enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      3'd2: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      3'd3: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      3'd4: enc_word = {imm[31:12], rd, opcode};
      3'd5: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: bad_fmt = 1'b1;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  always_comb begin
    range_err = 1'b0;
    case (fmt)
      3'd1, 3'd2: range_err = ($signed(imm) < -32'sd2048) || ($signed(imm) > 32'sd2047);
      3'd3: range_err = ($signed(imm) < -32'sd4096) || ($signed(imm) > 32'sd4094) || imm[0];
      3'd4: range_err = |imm[11:0];
      3'd5: range_err = ($signed(imm) < -32'sd1048576) || ($signed(imm) > 32'sd1048574) || imm[0];
      default: range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  // Held low during reset so the loader never sees a handshake it cannot complete.
  assign in_ready = !full && !flush && !rst;
  assign accept = in_valid && in_ready;
  assign push   = accept && !bad_fmt && !range_err;
  assign pop    = !empty && out_ready && !flush;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    addr_d    = addr_q;
    last_d    = last_q;
    enc_err_d = accept && (bad_fmt || range_err);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      addr_d   = BASE_ADDR;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        addr_d   = addr_q + 32'd4;
        last_d   = mem_q[rd_ptr_q];
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage has no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= enc_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      addr_q    <= BASE_ADDR;
      last_q    <= 32'h0;
      enc_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      last_q    <= last_d;
      enc_err_q <= enc_err_d;
    end
  end

  assign out_valid = !empty;
  assign out_instr = empty ? last_q : mem_q[rd_ptr_q];
  assign out_addr  = addr_q;
  assign count     = count_q;
  assign enc_err   = enc_err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, enc_err;
  logic [2:0]  fmt, funct3;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm, out_instr, out_addr;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .count(count), .enc_err(enc_err)
  );

  always #5 clk = ~clk;

  task automatic set_bundle(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                            input logic [4:0] s2, input logic [31:0] im);
    fmt = f; opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  // Presents the current bundle for exactly one edge, returns 1 time unit after it.
  task automatic push_one;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_flush;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr: got %h expected 0", out_instr); end
    n_checks++; if (out_addr !== 32'h0) begin n_fail++; $display("FAIL reset_out_addr: got %h expected 0", out_addr); end
    n_checks++; if (enc_err !== 1'b0) begin n_fail++; $display("FAIL reset_enc_err: got %b expected 0", enc_err); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_r_type;
    set_bundle(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h0);
    push_one();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL r_latency_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_instr !== 32'h003100B3) begin n_fail++; $display("FAIL r_instr: got %h expected 003100b3", out_instr); end
    n_checks++; if (out_addr !== 32'h0) begin n_fail++; $display("FAIL r_addr: got %h expected 0", out_addr); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL r_count: got %0d expected 1", count); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL r_pop_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_addr !== 32'h4) begin n_fail++; $display("FAIL r_pop_addr: got %h expected 4", out_addr); end
    n_checks++; if (out_instr !== 32'h003100B3) begin n_fail++; $display("FAIL r_hold_instr: got %h expected 003100b3", out_instr); end
  endtask

  task automatic test_i_s_back_to_back;
    do_flush();
    set_bundle(3'd1, 7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
    push_one();
    n_checks++; if (out_instr !== 32'hFFF00293) begin n_fail++; $display("FAIL i_instr: got %h expected fff00293", out_instr); end
    n_checks++; if (out_addr !== 32'h0) begin n_fail++; $display("FAIL i_addr: got %h expected 0", out_addr); end
    // Push S while popping I: occupancy must stay at 1.
    set_bundle(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    out_ready = 1'b1;
    push_one();
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL s_simul_count: got %0d expected 1", count); end
    n_checks++; if (out_instr !== 32'h0020A423) begin n_fail++; $display("FAIL s_instr: got %h expected 0020a423", out_instr); end
    n_checks++; if (out_addr !== 32'h4) begin n_fail++; $display("FAIL s_addr: got %h expected 4", out_addr); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL s_drain_count: got %0d expected 0", count); end
    n_checks++; if (out_addr !== 32'h8) begin n_fail++; $display("FAIL s_drain_addr: got %h expected 8", out_addr); end
  endtask

  task automatic test_b_full;
    logic [31:0] exp;
    do_flush();
    set_bundle(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
    push_one();
    n_checks++; if (out_instr !== 32'hFE000EE3) begin n_fail++; $display("FAIL b_instr: got %h expected fe000ee3", out_instr); end
    for (int i = 1; i < 4; i++) begin
      set_bundle(3'd0, 7'h33, 3'd0, 7'd0, 5'(i), 5'd2, 5'd3, 32'h0);
      push_one();
    end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d expected 4", count); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    set_bundle(3'd0, 7'h33, 3'd0, 7'd0, 5'd9, 5'd2, 5'd3, 32'h0);
    push_one();
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_blocked_count: got %0d expected 4", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = (i == 0) ? 32'hFE000EE3 : (32'h00310033 | (32'(i) << 7));
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b expected 1", i, out_valid); end
      n_checks++; if (out_instr !== exp) begin n_fail++; $display("FAIL drain_instr[%0d]: got %h expected %h", i, out_instr, exp); end
      n_checks++; if (out_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL drain_addr[%0d]: got %h expected %h", i, out_addr, 32'(4 * i)); end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_illegal;
    do_flush();
    set_bundle(3'd4, 7'h37, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h1234_5000);
    push_one();
    set_bundle(3'd6, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h0);
    push_one();
    n_checks++; if (enc_err !== 1'b1) begin n_fail++; $display("FAIL fmt6_enc_err: got %b expected 1", enc_err); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL fmt6_count: got %0d expected 1", count); end
    set_bundle(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd2048);
    push_one();
`ifdef IMM_RANGE_CHECK_EN
    n_checks++; if (enc_err !== 1'b1) begin n_fail++; $display("FAIL imm_range_enc_err: got %b expected 1", enc_err); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL imm_range_count: got %0d expected 1", count); end
`else
    n_checks++; if (enc_err !== 1'b0) begin n_fail++; $display("FAIL imm_trunc_enc_err: got %b expected 0", enc_err); end
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL imm_trunc_count: got %0d expected 2", count); end
`endif
    out_ready = 1'b1;
    n_checks++; if (out_instr !== 32'h123450B7) begin n_fail++; $display("FAIL u_instr: got %h expected 123450b7", out_instr); end
    @(posedge clk); #1;
`ifndef IMM_RANGE_CHECK_EN
    n_checks++; if (out_instr !== 32'h80000013) begin n_fail++; $display("FAIL imm_trunc_instr: got %h expected 80000013", out_instr); end
    n_checks++; if (out_addr !== 32'h4) begin n_fail++; $display("FAIL imm_trunc_addr: got %h expected 4", out_addr); end
    @(posedge clk); #1;
`endif
    out_ready = 1'b0;
    n_checks++; if (enc_err !== 1'b0) begin n_fail++; $display("FAIL enc_err_pulse_end: got %b expected 0", enc_err); end
  endtask

  task automatic test_flush;
    do_flush();
    for (int i = 0; i < 3; i++) begin
      set_bundle(3'd0, 7'h33, 3'd0, 7'd0, 5'(i), 5'd2, 5'd3, 32'h0);
      push_one();
    end
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL pre_flush_count: got %0d expected 3", count); end
    // Flush while a bundle and a pop are both requested: flush must win.
    in_valid = 1'b1; out_ready = 1'b1;
    do_flush();
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_addr !== 32'h0) begin n_fail++; $display("FAIL flush_addr: got %h expected 0", out_addr); end
    set_bundle(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);
    push_one();
    n_checks++; if (out_instr !== 32'h008000EF) begin n_fail++; $display("FAIL j_instr: got %h expected 008000ef", out_instr); end
    n_checks++; if (out_addr !== 32'h0) begin n_fail++; $display("FAIL j_addr: got %h expected 0", out_addr); end
  endtask

  task automatic test_reset_mid_stream;
    do_flush();
    for (int i = 0; i < 2; i++) begin
      set_bundle(3'd0, 7'h33, 3'd0, 7'd0, 5'd4, 5'd2, 5'd3, 32'h0);
      push_one();
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_addr !== 32'h4) begin n_fail++; $display("FAIL mid_pre_addr: got %h expected 4", out_addr); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_addr !== 32'h0) begin n_fail++; $display("FAIL mid_rst_addr: got %h expected 0", out_addr); end
    n_checks++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL mid_rst_instr: got %h expected 0", out_instr); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_in_ready: got %b expected 0", in_ready); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_bundle(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    test_reset();
    test_r_type();
    test_i_s_back_to_back();
    test_b_full();
    test_illegal();
    test_flush();
    test_reset_mid_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
